// File: rtl/rv32i_mc_ctrl.sv
// rv32i_mc_ctrl: multi-cycle control FSM for the RV32I core.
// Sequences fetch/decode/exec/mem/wb, raises a sticky trap, counts retires.
module rv32i_mc_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_valid,
  input  logic [31:0] ir,
  input  logic        br_taken,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        ir_we,
  output logic [2:0]  cu_immtype,
  output logic        alu_srca,
  output logic        alu_srcb,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [31:0] instret
);

  localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    FETCH, DECODE, EXEC, MEM, WB, TRAP
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic [1:0]    cause_nx;
  logic          retire;

  logic [6:0] opc;
  logic is_lui, is_auipc, is_jal, is_jalr;
  logic is_branch, is_load, is_store;
  logic is_opimm, is_op, is_fence;
  logic legal;
  logic unused_ir;

  assign opc       = ir[6:0];
  assign is_lui    = (opc == 7'b0110111);
  assign is_auipc  = (opc == 7'b0010111);
  assign is_jal    = (opc == 7'b1101111);
  assign is_jalr   = (opc == 7'b1100111);
  assign is_branch = (opc == 7'b1100011);
  assign is_load   = (opc == 7'b0000011);
  assign is_store  = (opc == 7'b0100011);
  assign is_opimm  = (opc == 7'b0010011);
  assign is_op     = (opc == 7'b0110011);
  assign is_fence  = (opc == 7'b0001111);
  assign legal     = is_lui | is_auipc | is_jal
                   | is_jalr | is_branch | is_load
                   | is_store | is_opimm | is_op
                   | is_fence;
  assign unused_ir = ^ir[31:12];

  assign trap = (state == TRAP);

  // immediate format follows the held opcode
  always_comb begin
    cu_immtype = 3'b000;
    unique case (1'b1)
      is_load, is_opimm, is_jalr: cu_immtype = 3'b000;
      is_store:                   cu_immtype = 3'b001;
      is_branch:                  cu_immtype = 3'b010;
      is_lui, is_auipc:           cu_immtype = 3'b011;
      is_jal:                     cu_immtype = 3'b100;
      default:                    cu_immtype = 3'b000;
    endcase
  end

  // state register, mem wait counter, trap cause
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FETCH;
      cnt        <= '0;
      trap_cause <= 2'b00;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      trap_cause <= cause_nx;
    end
  end

  // retired instruction counter, wraps naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret <= '0;
    end else if (retire) begin
      instret <= instret + 32'd1;
    end
  end

  // next state and strobes; everything held low while rst is high
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    cause_nx = trap_cause;
    retire   = 1'b0;
    imem_req = 1'b0;
    ir_we    = 1'b0;
    alu_srca = 1'b0;
    alu_srcb = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    reg_we   = 1'b0;
    wb_sel   = 2'b00;
    pc_we    = 1'b0;
    pc_sel   = 2'b00;
    if (!rst) begin
      unique case (state)
        FETCH: begin
          imem_req = 1'b1;
          if (imem_valid) begin
            ir_we    = 1'b1;
            state_nx = DECODE;
          end
        end
        DECODE: begin
          if (!legal) begin
            state_nx = TRAP;
            cause_nx = 2'b01;
          end else if (is_fence) begin
            pc_we    = 1'b1;
            retire   = 1'b1;
            state_nx = FETCH;
          end else begin
            state_nx = EXEC;
          end
        end
        EXEC: begin
          alu_srca = is_auipc | is_jal | is_branch;
          alu_srcb = ~is_op;
          if (is_branch) begin
            pc_we    = 1'b1;
            pc_sel   = br_taken ? 2'b01 : 2'b00;
            retire   = 1'b1;
            state_nx = FETCH;
          end else if (is_load | is_store) begin
            cnt_nx   = '0;
            state_nx = MEM;
          end else begin
            state_nx = WB;
          end
        end
        MEM: begin
          dmem_req = 1'b1;
          dmem_we  = is_store;
          if (dmem_ready) begin
            if (is_store) begin
              pc_we    = 1'b1;
              retire   = 1'b1;
              state_nx = FETCH;
            end else begin
              state_nx = WB;
            end
          end else if (cnt == TMO_LAST) begin
            state_nx = TRAP;
            cause_nx = 2'b10;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        WB: begin
          reg_we = (ir[11:7] != 5'd0);
          if (is_load) begin
            wb_sel = 2'b01;
          end else if (is_jal | is_jalr) begin
            wb_sel = 2'b10;
          end
          if (is_jal) begin
            pc_sel = 2'b01;
          end else if (is_jalr) begin
            pc_sel = 2'b10;
          end
          pc_we    = 1'b1;
          retire   = 1'b1;
          state_nx = FETCH;
        end
        TRAP: begin
          state_nx = TRAP;
        end
        default: begin
          state_nx = FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_mc_ctrl.sv
// tb_rv32i_mc_ctrl: randomized instruction stream against a
// per-instruction cycle-trace model of the control unit.
module tb_rv32i_mc_ctrl;

  localparam int TMO = 15;

  logic        clk;
  logic        rst;
  logic        imem_valid;
  logic [31:0] ir;
  logic        br_taken;
  logic        dmem_ready;
  logic        imem_req;
  logic        ir_we;
  logic [2:0]  cu_immtype;
  logic        alu_srca;
  logic        alu_srcb;
  logic        dmem_req;
  logic        dmem_we;
  logic        reg_we;
  logic [1:0]  wb_sel;
  logic        pc_we;
  logic [1:0]  pc_sel;
  logic        trap;
  logic [1:0]  trap_cause;
  logic [31:0] instret;

  rv32i_mc_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .imem_valid(imem_valid), .ir(ir),
    .br_taken(br_taken), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .ir_we(ir_we),
    .cu_immtype(cu_immtype),
    .alu_srca(alu_srca), .alu_srcb(alu_srcb),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .reg_we(reg_we), .wb_sel(wb_sel),
    .pc_we(pc_we), .pc_sel(pc_sel),
    .trap(trap), .trap_cause(trap_cause),
    .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        imem_req, ir_we, dmem_req, dmem_we;
    logic        reg_we, pc_we, srca, srcb, trap;
    logic        chk_alu, chk_wb, chk_pc;
    logic [1:0]  wb_sel, pc_sel, cause;
    logic [2:0]  imm;
    logic [31:0] instret;
  } exp_t;

  typedef enum {L_INSTRET, L_IMM, L_TRAP, L_CAUSE,
                L_IMEMREQ, L_IRWE} lsel_t;

  typedef struct {
    lsel_t       s;
    string       nm;
    logic [31:0] v;
  } lit_t;

  exp_t eq[$];
  lit_t lq[$];

  int total = 0;
  int bad   = 0;

  logic [31:0] cur_ir;
  logic [31:0] m_instret;
  logic        m_trap;
  logic [1:0]  m_cause;

  logic [6:0] ops [0:9] = '{7'b0110111, 7'b0010111,
    7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011,
    7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111};

  localparam logic [6:0] LUI = 7'b0110111;
  localparam logic [6:0] AUIPC = 7'b0010111;
  localparam logic [6:0] JAL = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;
  localparam logic [6:0] BR = 7'b1100011;
  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;
  localparam logic [6:0] OPI = 7'b0010011;
  localparam logic [6:0] OP = 7'b0110011;
  localparam logic [6:0] FENCE = 7'b0001111;

  function automatic logic [2:0] imm_of(input logic [6:0] op);
    case (op)
      LD, OPI, JALR: return 3'b000;
      ST:            return 3'b001;
      BR:            return 3'b010;
      LUI, AUIPC:    return 3'b011;
      JAL:           return 3'b100;
      default:       return 3'b000;
    endcase
  endfunction

  function automatic logic is_legal(input logic [6:0] op);
    for (int i = 0; i < 10; i++)
      if (ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic exp_t base();
    exp_t e;
    e = '{default: 0};
    e.imm     = imm_of(cur_ir[6:0]);
    e.trap    = m_trap;
    e.cause   = m_cause;
    e.instret = m_instret;
    return e;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  exp_t        ce;
  lit_t        cl;
  logic [31:0] la;

  // single compare point, mid-cycle
  always @(negedge clk) begin
    if (eq.size() != 0) begin
      ce = eq.pop_front();
      chk("imem_req", 32'(imem_req), 32'(ce.imem_req));
      chk("ir_we", 32'(ir_we), 32'(ce.ir_we));
      chk("dmem_req", 32'(dmem_req), 32'(ce.dmem_req));
      chk("reg_we", 32'(reg_we), 32'(ce.reg_we));
      chk("pc_we", 32'(pc_we), 32'(ce.pc_we));
      chk("cu_immtype", 32'(cu_immtype), 32'(ce.imm));
      chk("trap", 32'(trap), 32'(ce.trap));
      chk("trap_cause", 32'(trap_cause), 32'(ce.cause));
      chk("instret", instret, ce.instret);
      if (ce.dmem_req)
        chk("dmem_we", 32'(dmem_we), 32'(ce.dmem_we));
      if (ce.chk_alu) begin
        chk("alu_srca", 32'(alu_srca), 32'(ce.srca));
        chk("alu_srcb", 32'(alu_srcb), 32'(ce.srcb));
      end
      if (ce.chk_wb)
        chk("wb_sel", 32'(wb_sel), 32'(ce.wb_sel));
      if (ce.chk_pc)
        chk("pc_sel", 32'(pc_sel), 32'(ce.pc_sel));
    end
    while (lq.size() != 0) begin
      cl = lq.pop_front();
      case (cl.s)
        L_INSTRET: la = instret;
        L_IMM:     la = 32'(cu_immtype);
        L_TRAP:    la = 32'(trap);
        L_CAUSE:   la = 32'(trap_cause);
        L_IMEMREQ: la = 32'(imem_req);
        default:   la = 32'(ir_we);
      endcase
      chk(cl.nm, la, cl.v);
    end
  end

  task automatic lit(input lsel_t s, input string nm,
                     input logic [31:0] v);
    lit_t l;
    l.s = s; l.nm = nm; l.v = v;
    lq.push_back(l);
  endtask

  task automatic cyc(input logic iv, input logic rdy,
                     input logic bt, input exp_t e);
    @(posedge clk);
    #1;
    rst        = 1'b0;
    imem_valid = iv;
    dmem_ready = rdy;
    br_taken   = bt;
    ir         = cur_ir;
    eq.push_back(e);
  endtask

  task automatic do_reset();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      rst        = 1'b1;
      imem_valid = 1'b1;
      dmem_ready = 1'b1;
      br_taken   = 1'b1;
      m_instret  = '0;
      m_trap     = 1'b0;
      m_cause    = 2'b00;
      e = base();
      eq.push_back(e);
    end
  endtask

  task automatic idle_fetch();
    exp_t e;
    e = base();
    e.imem_req = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, e);
  endtask

  task automatic trap_cycles(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e = base();
      cyc(1'b1, 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), e);
    end
  endtask

  // one instruction: fw fetch stalls, mw mem stalls,
  // reset injected at mem cycle mem_abort (-1: never)
  task automatic run_instr(input logic [31:0] ins,
                           input int fw, input int mw,
                           input logic bt,
                           input int mem_abort);
    exp_t e;
    logic [6:0] op;
    logic rdy;
    op = ins[6:0];
    for (int i = 0; i < fw; i++) idle_fetch();
    e = base();
    e.imem_req = 1'b1;
    e.ir_we    = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, e);
    cur_ir = ins;
    e = base();
    if (!is_legal(op)) begin
      cyc(1'b0, 1'b0, 1'b0, e);
      m_trap  = 1'b1;
      m_cause = 2'b01;
      trap_cycles(3);
      return;
    end
    if (op == FENCE) begin
      e.pc_we = 1'b1; e.chk_pc = 1'b1; e.pc_sel = 2'b00;
      cyc(1'b0, 1'b0, 1'b0, e);
      m_instret++;
      return;
    end
    cyc(1'b0, 1'b0, 1'b0, e);
    e = base();
    e.chk_alu = 1'b1;
    e.srca = (op == AUIPC) || (op == JAL) || (op == BR);
    e.srcb = (op != OP);
    if (op == BR) begin
      e.pc_we = 1'b1; e.chk_pc = 1'b1;
      e.pc_sel = bt ? 2'b01 : 2'b00;
      cyc(1'b0, 1'b0, bt, e);
      m_instret++;
      return;
    end
    cyc(1'b0, 1'b0, bt, e);
    if (op == LD || op == ST) begin
      for (int i = 0; ; i++) begin
        if (i == mem_abort) begin
          do_reset();
          return;
        end
        rdy = (i == mw);
        e = base();
        e.dmem_req = 1'b1;
        e.dmem_we  = (op == ST);
        if (rdy && op == ST) begin
          e.pc_we = 1'b1; e.chk_pc = 1'b1; e.pc_sel = 2'b00;
        end
        cyc(1'b0, rdy, 1'b0, e);
        if (rdy) begin
          if (op == ST) begin
            m_instret++;
            return;
          end
          break;
        end
        if (i + 1 == TMO) begin
          m_trap  = 1'b1;
          m_cause = 2'b10;
          trap_cycles(3);
          return;
        end
      end
    end
    e = base();
    e.reg_we = (ins[11:7] != 5'd0);
    e.chk_wb = 1'b1;
    e.wb_sel = (op == LD) ? 2'b01 :
               (op == JAL || op == JALR) ? 2'b10 : 2'b00;
    e.pc_we  = 1'b1;
    e.chk_pc = 1'b1;
    e.pc_sel = (op == JAL) ? 2'b01 :
               (op == JALR) ? 2'b10 : 2'b00;
    cyc(1'b0, 1'b0, 1'b0, e);
    m_instret++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst = 1'b1;
    imem_valid = 1'b0;
    dmem_ready = 1'b0;
    br_taken = 1'b0;
    cur_ir = '0;
    ir = '0;
    m_instret = '0;
    m_trap = 1'b0;
    m_cause = 2'b00;
    do_reset();
    lit(L_INSTRET, "reset_instret", 32'd0);
    lit(L_IMEMREQ, "reset_imem_req", 32'd0);

    run_instr(32'h00500093, 2, 0, 1'b0, -1);
    idle_fetch();
    lit(L_INSTRET, "addi_instret", 32'd1);

    run_instr(32'h00208463, 0, 0, 1'b1, -1);
    idle_fetch();
    lit(L_IMM, "beq_immtype", 32'd2);
    lit(L_INSTRET, "beq_instret", 32'd2);

    run_instr(32'h0000A083, 1, 3, 1'b0, -1);
    idle_fetch();
    lit(L_INSTRET, "lw_instret", 32'd3);

    run_instr(32'h0000A083, 0, TMO - 1, 1'b0, -1);
    run_instr(32'h0000A023, 0, TMO - 1, 1'b0, -1);
    run_instr(32'h0000000F, 0, 0, 1'b0, -1);
    idle_fetch();
    lit(L_INSTRET, "edge_fence_instret", 32'd6);
    lit(L_TRAP, "edge_trap", 32'd0);

    run_instr(32'h0000007F, 0, 0, 1'b0, -1);
    lit(L_CAUSE, "illegal_cause", 32'd1);
    lit(L_INSTRET, "illegal_instret", 32'd6);
    lit(L_IRWE, "trap_ir_we", 32'd0);
    do_reset();
    lit(L_TRAP, "rst_trap", 32'd0);
    lit(L_INSTRET, "rst_instret", 32'd0);

    run_instr(32'h0000A023, 0, 99, 1'b0, -1);
    lit(L_TRAP, "tmo_trap", 32'd1);
    lit(L_CAUSE, "tmo_cause", 32'd2);
    lit(L_IMEMREQ, "tmo_imem_req", 32'd0);
    do_reset();

    run_instr(32'h0000A083, 0, 10, 1'b0, 2);
    lit(L_INSTRET, "abort_instret", 32'd0);

    @(posedge clk);
    #1;
    rst = 1'b0;
    imem_valid = 1'b0;
    dmem_ready = 1'b0;
    br_taken = 1'b0;
    force dut.instret = 32'hFFFF_FFFF;
    #1;
    release dut.instret;
    m_instret = 32'hFFFF_FFFF;
    e = base();
    e.imem_req = 1'b1;
    eq.push_back(e);
    run_instr(32'h0000006F, 0, 0, 1'b0, -1);
    idle_fetch();
    lit(L_IMM, "jal_immtype", 32'd4);
    lit(L_INSTRET, "jal_wrap", 32'd0);

    for (int n = 0; n < 80; n++) begin
      logic [31:0] ins;
      int pick;
      int mw;
      int ab;
      ins = $urandom();
      ins[11:7] = 5'($urandom_range(0, 3));
      pick = int'($urandom_range(0, 19));
      if (pick == 0) ins[6:0] = 7'h7F;
      else if (pick == 1) ins[6:0] = 7'h53;
      else ins[6:0] = ops[$urandom_range(0, 9)];
      if ($urandom_range(0, 9) == 0)
        mw = int'($urandom_range(13, 17));
      else
        mw = int'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0)
        ab = int'($urandom_range(0, mw));
      else
        ab = -1;
      run_instr(ins, int'($urandom_range(0, 3)), mw,
                1'($urandom_range(0, 1)), ab);
      if (m_trap) do_reset();
    end

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
